// File: rtl/grid_pkg.sv
// Shared definitions for the paper-roll grid datapath: character codes,
// loader FSM states and the row-major cell index helper.
// Optional feature macro used by this slice: GRID_ROLL_COUNT_EN.
package grid_pkg;

    localparam logic [7:0] CH_ROLL  = 8'h40;  // '@'
    localparam logic [7:0] CH_EMPTY = 8'h2E;  // '.'
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;

    typedef enum logic [1:0] {
        LOAD,
        DRAIN,
        REPORT
    } loader_state_t;

    // Row-major cell index: bit r*width + c of the occupancy grid.
    function automatic int cell_index(input int row, input int col, input int width);
        return row * width + col;
    endfunction

endpackage

// File: rtl/grid_stream_loader_if.sv
// Byte-stream input and frame output channels of the grid loader.
// The slave modport is the loader's view; master is the environment's view.
// roll_count exists only when GRID_ROLL_COUNT_EN is defined.
interface grid_stream_loader_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) ();

    localparam int ROW_W = $clog2(DEPTH + 1);
    localparam int COL_W = $clog2(WIDTH + 1);
    localparam int CNT_W = $clog2(WIDTH * DEPTH + 1);

    logic                     in_valid;
    logic                     in_ready;
    logic [7:0]               in_data;
    logic                     in_last;
    logic                     out_valid;
    logic                     out_ready;
    logic [WIDTH*DEPTH-1:0]   grid;
    logic [ROW_W-1:0]         rows;
    logic [COL_W-1:0]         cols;
    logic                     err;
`ifdef GRID_ROLL_COUNT_EN
    logic [CNT_W-1:0]         roll_count;
`endif

    modport slave (
`ifdef GRID_ROLL_COUNT_EN
        output roll_count,
`endif
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, grid, rows, cols, err
    );

    modport master (
`ifdef GRID_ROLL_COUNT_EN
        input  roll_count,
`endif
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, grid, rows, cols, err
    );

endinterface

// File: rtl/grid_char_decode.sv
// Combinational classifier for one puzzle-text byte.
module grid_char_decode
    import grid_pkg::*;
(
    input  logic [7:0] data,
    output logic       is_roll,
    output logic       is_empty,
    output logic       is_lf,
    output logic       is_cr,
    output logic       is_bad
);

    // Exactly one class flag is high for any byte.
    always_comb begin
        is_roll  = (data == CH_ROLL);
        is_empty = (data == CH_EMPTY);
        is_lf    = (data == CH_LF);
        is_cr    = (data == CH_CR);
        is_bad   = !(is_roll || is_empty || is_lf || is_cr);
    end

endmodule

// File: rtl/grid_stream_loader.sv
// Loads an ASCII puzzle frame into a row-major occupancy grid and presents
// the finished frame (grid, rows, cols, err) until downstream accepts it.
// Define GRID_ROLL_COUNT_EN to add the per-frame '@' counter output.
module grid_stream_loader
    import grid_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    grid_stream_loader_if.slave bus
);

    localparam int ROW_W = $clog2(DEPTH + 1);
    localparam int COL_W = $clog2(WIDTH + 1);
    localparam int CELLS = WIDTH * DEPTH;
    localparam int IDX_W = $clog2(CELLS);
    localparam int CNT_W = $clog2(CELLS + 1);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(WIDTH);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(DEPTH);

    loader_state_t    state_q, state_d;
    logic [CELLS-1:0] grid_q, grid_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [COL_W-1:0] cols_q, cols_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] roll_q, roll_d;
    logic             is_roll, is_empty, is_lf, is_cr, is_bad;
    logic             bad, blank_end;
    logic             in_ready, out_valid;

    grid_char_decode u_decode (
        .data     (bus.in_data),
        .is_roll  (is_roll),
        .is_empty (is_empty),
        .is_lf    (is_lf),
        .is_cr    (is_cr),
        .is_bad   (is_bad)
    );

    // Next-state and datapath update for one accepted byte or frame handshake.
    always_comb begin
        // NOTE: every value driven here gets a default first, so no path can infer a latch.
        state_d   = state_q;
        grid_d    = grid_q;
        row_d     = row_q;
        col_d     = col_q;
        cols_d    = cols_q;
        err_d     = err_q;
        roll_d    = roll_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        bad       = 1'b0;
        blank_end = 1'b0;
        unique case (state_q)
            LOAD: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    if (is_roll || is_empty) begin
                        if (col_q == COL_MAX || row_q == ROW_MAX) begin
                            bad = 1'b1;
                        end else begin
                            if (is_roll) begin
                                grid_d[IDX_W'(cell_index(int'(row_q), int'(col_q), WIDTH))] = 1'b1;
                                roll_d = roll_q + 1'b1;
                            end
                            col_d = col_q + 1'b1;
                        end
                    end else if (is_lf) begin
                        if (col_q != '0) begin
                            if (row_q == '0) cols_d = col_q;
                            else if (col_q != cols_q) bad = 1'b1;
                            row_d = row_q + 1'b1;
                            col_d = '0;
                        end else if (row_q != '0) begin
                            blank_end = 1'b1;
                        end
                    end else if (is_bad) begin
                        bad = 1'b1;
                    end
                    // The final byte closes any open row with the same width rule as LF.
                    if (bus.in_last && !bad && col_d != '0) begin
                        if (row_d == '0) cols_d = col_d;
                        else if (col_d != cols_d) bad = 1'b1;
                        row_d = row_d + 1'b1;
                        col_d = '0;
                    end
                    if (bad) begin
                        err_d   = 1'b1;
                        state_d = bus.in_last ? REPORT : DRAIN;
                    end else if (bus.in_last) begin
                        state_d = REPORT;
                    end else if (blank_end) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                in_ready = 1'b1;
                if (bus.in_valid && bus.in_last) state_d = REPORT;
            end
            REPORT: begin
                out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = LOAD;
                    grid_d  = '0;
                    row_d   = '0;
                    col_d   = '0;
                    cols_d  = '0;
                    err_d   = 1'b0;
                    roll_d  = '0;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) state_q <= LOAD;
        else        state_q <= state_d;
    end

    // Frame datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the grid is a flop bank, not a RAM, so it is reset with the rest of the frame
            // and a partial frame can never leak into the next report.
            grid_q <= '0;
            row_q  <= '0;
            col_q  <= '0;
            cols_q <= '0;
            err_q  <= 1'b0;
            roll_q <= '0;
        end else begin
            grid_q <= grid_d;
            row_q  <= row_d;
            col_q  <= col_d;
            cols_q <= cols_d;
            err_q  <= err_d;
            roll_q <= roll_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.grid      = grid_q;
    assign bus.rows      = row_q;
    assign bus.cols      = cols_q;
    assign bus.err       = err_q;
`ifdef GRID_ROLL_COUNT_EN
    assign bus.roll_count = roll_q;
`else
    // Counter is unused without the feature; keep it from being flagged as dead logic.
    logic unused_roll;
    assign unused_roll = ^roll_q;
`endif

endmodule

// File: tb/tb_grid_stream_loader.sv
// Directed self-checking bench for grid_stream_loader (WIDTH=DEPTH=16).
// Roll-count checks are compiled in when GRID_ROLL_COUNT_EN is defined.
module tb_grid_stream_loader;
    import grid_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    grid_stream_loader_if #(.WIDTH(16), .DEPTH(16)) bus ();

    grid_stream_loader #(.WIDTH(16), .DEPTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present one byte after gap idle cycles; returns #1 after the accepting edge.
    task automatic send_byte(input logic [7:0] d, input bit last, input int gap);
        int n;
        n = 0;
        repeat (gap) begin @(posedge clk); #1; end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        while (!bus.in_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (!bus.in_ready) check("in_ready_timeout", 0, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic send_str(input string s, input bit last_on_end, input int gap);
        for (int i = 0; i < s.len(); i++)
            send_byte(s[i], last_on_end && (i == s.len() - 1), gap);
    endtask

    task automatic expect_frame(input string tag, input logic [255:0] g, input int r,
                                input int c, input bit e, input int rc);
        check({tag, ".out_valid"}, bus.out_valid, 1);
        check({tag, ".err"}, bus.err, e);
        if (!e) begin
            check({tag, ".grid"}, bus.grid, g);
            check({tag, ".rows"}, bus.rows, r);
            check({tag, ".cols"}, bus.cols, c);
`ifdef GRID_ROLL_COUNT_EN
            check({tag, ".roll_count"}, bus.roll_count, rc);
`endif
        end
    endtask

    task automatic consume(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({tag, ".drop_valid"}, bus.out_valid, 0);
        check({tag, ".clr_grid"}, bus.grid, 0);
        check({tag, ".ready_again"}, bus.in_ready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] g;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        check("rst.out_valid", bus.out_valid, 0);
        check("rst.in_ready", bus.in_ready, 1);
        check("rst.grid", bus.grid, 0);
        check("rst.rows", bus.rows, 0);
        check("rst.cols", bus.cols, 0);
        check("rst.err", bus.err, 0);

        // 1: two rows, in_last on the final LF
        send_str("@.@\n.@.\n", 1'b1, 0);
        expect_frame("t1", 256'h20005, 2, 3, 0, 3);
        consume("t1");

        // 2: no trailing LF, in_valid gaps, one-cycle latency
        send_str("@@\n@", 1'b0, 2);
        check("t2.not_yet", bus.out_valid, 0);
        send_byte("@", 1'b1, 1);
        expect_frame("t2", 256'h30003, 2, 2, 0, 4);
        consume("t2");

        // 3: ragged rows error, then drain until in_last
        send_str("@@@\n@@\n", 1'b0, 0);
        check("t3.drain_ready", bus.in_ready, 1);
        check("t3.drain_novalid", bus.out_valid, 0);
        send_str("..", 1'b0, 0);
        check("t3.still_drain", bus.out_valid, 0);
        send_byte(".", 1'b1, 0);
        expect_frame("t3", 0, 0, 0, 1, 0);
        consume("t3");

        // 4a: 16 cells fits exactly
        send_str("@@@@@@@@@@@@@@@@", 1'b1, 0);
        expect_frame("t4full", 256'hFFFF, 1, 16, 0, 16);
        consume("t4full");

        // 4b: 17th cell overflows the row
        send_str("@@@@@@@@@@@@@@@@@\n", 1'b1, 0);
        expect_frame("t4col", 0, 0, 0, 1, 0);
        consume("t4col");

        // 4c: 16 rows fit exactly
        g = '0;
        for (int r = 0; r < 16; r++) begin
            send_str("@\n", r == 15, 0);
            g[r*16] = 1'b1;
        end
        expect_frame("t4rows", g, 16, 1, 0, 16);
        consume("t4rows");

        // 4d: 17th row overflows the frame
        for (int r = 0; r < 17; r++) send_str("@\n", r == 16, 0);
        expect_frame("t4depth", 0, 0, 0, 1, 0);
        consume("t4depth");

        // Bad character carrying in_last goes straight to REPORT
        send_byte("x", 1'b1, 0);
        expect_frame("badch", 0, 0, 0, 1, 0);
        consume("badch");

        // Empty frame
        send_byte(CH_LF, 1'b1, 0);
        expect_frame("empty", 0, 0, 0, 0, 0);
        consume("empty");

        // Blank-line end drains the rest without counting it
        send_str("@\n\n", 1'b0, 0);
        check("blank.drain", bus.out_valid, 0);
        send_str("@@", 1'b1, 0);
        expect_frame("blank", 256'h1, 1, 1, 0, 1);
        consume("blank");

        // 5: hold in REPORT under backpressure
        send_str("@.\n.@\n", 1'b1, 0);
        for (int i = 0; i < 10; i++) begin
            check("t5.hold_valid", bus.out_valid, 1);
            check("t5.hold_ready", bus.in_ready, 0);
            check("t5.hold_grid", bus.grid, 256'h20001);
            check("t5.hold_rows", bus.rows, 2);
            check("t5.hold_cols", bus.cols, 2);
            @(posedge clk); #1;
        end
        consume("t5");

        // Second frame with leading LF and CR bytes ignored
        send_byte(CH_LF, 1'b0, 0);
        send_byte(CH_CR, 1'b0, 0);
        send_str(".@", 1'b0, 1);
        send_byte(CH_CR, 1'b0, 0);
        send_str("\n@.", 1'b0, 0);
        send_byte(CH_CR, 1'b0, 0);
        send_byte(CH_LF, 1'b1, 0);
        expect_frame("t5b", 256'h10002, 2, 2, 0, 2);
        consume("t5b");

        // Async reset mid-frame
        send_str("@@\n@", 1'b0, 0);
        check("rstmid.pre_rows", bus.rows, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid.grid", bus.grid, 0);
        check("rstmid.rows", bus.rows, 0);
        check("rstmid.cols", bus.cols, 0);
        check("rstmid.out_valid", bus.out_valid, 0);
        check("rstmid.err", bus.err, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Async reset while reporting
        send_str("@\n", 1'b1, 0);
        check("rstrep.pre_valid", bus.out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rstrep.out_valid", bus.out_valid, 0);
        check("rstrep.rows", bus.rows, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Clean frame after reset
        send_str("@@\n", 1'b1, 0);
        expect_frame("post", 256'h3, 1, 2, 0, 2);
        consume("post");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
